// File: rtl/ahb_ram_slave.sv
// AHB-Lite single-port word RAM slave with programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.

module ahb_ram_slave_lane #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    // Storage is intentionally not reset; contents are undefined until written.
    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

module ahb_ram_slave #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    localparam int         AW = DEPTH_LOG2 + 2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [1:0]    size;
    } req_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    req_t          req_q, req_d;

    logic          hready;
    logic          accept;
    logic          addr_err;
    logic          commit_we;
    logic [3:0]    byte_en;
    logic [31:0]   rdata;
    logic          unused_htrans;

    assign unused_htrans = HTRANS[0];

    always_comb begin
        addr_err = (HADDR[31:AW] != BASE_ADDR[31:AW])
                || HSIZE[2] || (HSIZE[1] && HSIZE[0])
                || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                || ((HSIZE == 3'b001) && HADDR[0]);
    end

    assign accept = HSEL && HTRANS[1] && hready;

    always_comb begin
        hready = 1'b1;
        HRESP  = 2'b00;
        HRDATA = 32'h0;
        case (state_q)
            S_DATA: begin
                hready = (cnt_q == 4'd0);
                if (cnt_q == 4'd0 && !req_q.write) HRDATA = rdata;
            end
            S_ERR1: begin
                hready = 1'b0;
                HRESP  = 2'b01;
            end
            S_ERR2: HRESP = 2'b01;
            default: ;
        endcase
    end

    assign HREADY = hready;

    // Every HREADY-high state shares the same pipelined accept rule, so the
    // next-state logic only special-cases the stalling states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        if (accept) begin
            req_d.addr  = HADDR[AW-1:0];
            req_d.write = HWRITE;
            req_d.size  = HSIZE[1:0];
            state_d     = addr_err ? S_ERR1 : S_DATA;
            cnt_d       = addr_err ? 4'd0 : WS;
        end else if (hready) begin
            state_d = S_IDLE;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        case (req_q.size)
            2'b00:   byte_en = 4'b0001 << req_q.addr[1:0];
            2'b01:   byte_en = req_q.addr[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Commit on the edge closing the completion cycle; a reset before then drops it.
    assign commit_we = (state_q == S_DATA) && (cnt_q == 4'd0) && req_q.write;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        ahb_ram_slave_lane #(.AW(DEPTH_LOG2)) u_lane (
            .clk   (clk),
            .we    (commit_we && byte_en[i]),
            .idx   (req_q.addr[AW-1:2]),
            .wdata (HWDATA[8*i +: 8]),
            .rdata (rdata[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: three instances (WAIT_STATES 1, 0, 3)
// share one bus; sel chooses which one a scenario targets.

module tb_ahb_ram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  hsel_v;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hrdata_a [3];
    logic        hready_a [3];
    logic [1:0]  hresp_a  [3];

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        ahb_ram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) u_dut (
            .clk    (clk),
            .reset  (reset),
            .HSEL   (hsel_v[g]),
            .HADDR  (haddr),
            .HTRANS (htrans),
            .HWRITE (hwrite),
            .HSIZE  (hsize),
            .HWDATA (hwdata),
            .HRDATA (hrdata_a[g]),
            .HREADY (hready_a[g]),
            .HRESP  (hresp_a[g])
        );
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
    endfunction

    function automatic int key_of(input int s, input logic [31:0] a);
        return (s << 20) | int'(a[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] r;
        bit          en;
        r = old;
        for (int b = 0; b < 4; b++) begin
            case (sz)
                3'd0:    en = (b == int'(a[1:0]));
                3'd1:    en = ((b / 2) == int'(a[1]));
                default: en = 1'b1;
            endcase
            if (en) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        return (a >= 32'h1000) || (sz >= 3'd3) || (sz == 3'd2 && a[1:0] != 2'b00)
            || (sz == 3'd1 && a[0]);
    endfunction

    task automatic drive_idle();
        hsel_v = '0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel_v      = '0;
        hsel_v[sel] = 1'b1;
        haddr       = a;
        htrans      = 2'b10;
        hwrite      = wr;
        hsize       = sz;
    endtask

    // One non-pipelined transfer on instance sel, checked against the model.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
        exp_t e;
        bit   err;
        int   key, waits, exp_waits;
        err    = is_err(a, sz);
        key    = key_of(sel, a);
        e.resp = err ? 2'b01 : 2'b00;
        e.rdata = 32'h0;
        if (!err) begin
            if (wr) model[key] = merge(model.exists(key) ? model[key] : 32'h0, wd, a, sz);
            else    e.rdata = model[key];
        end
        exp_waits = err ? 1 : ws_of(sel);
        sbq.push_back(e);
        @(negedge clk);
        drive_addr(wr, a, sz);
        @(negedge clk);
        drive_idle();
        hwdata = wr ? wd : 32'h0;
        waits  = 0;
        while (!hready_a[sel] && waits < 50) begin
            checks++;
            if (hresp_a[sel] !== e.resp || hrdata_a[sel] !== 32'h0) begin
                errors++;
                $display("FAIL wait_phase addr=%h got resp=%b rdata=%h want resp=%b rdata=0",
                         a, hresp_a[sel], hrdata_a[sel], e.resp);
            end
            waits++;
            @(negedge clk);
        end
        checks++;
        if (waits !== exp_waits) begin
            errors++;
            $display("FAIL wait_count addr=%h got %0d want %0d", a, waits, exp_waits);
        end
        e = sbq.pop_front();
        checks++;
        if (hrdata_a[sel] !== e.rdata || hresp_a[sel] !== e.resp) begin
            errors++;
            $display("FAIL completion addr=%h got rdata=%h resp=%b want rdata=%h resp=%b",
                     a, hrdata_a[sel], hresp_a[sel], e.rdata, e.resp);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        hwdata = 32'h0;
        drive_idle();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hready_a[i] !== 1'b1 || hresp_a[i] !== 2'b00 || hrdata_a[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got hready=%b resp=%b rdata=%h want 1 00 0",
                         i, hready_a[i], hresp_a[i], hrdata_a[i]);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word_rw();
        sel = 0;
        do_xfer(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
        do_xfer(1'b0, 32'h100, 3'd2, 32'h0);
        do_xfer(1'b1, 32'h000, 3'd2, 32'h0BADF00D);
    endtask

    task automatic test_subword();
        sel = 0;
        do_xfer(1'b1, 32'h104, 3'd2, 32'h11223344);
        do_xfer(1'b1, 32'h107, 3'd0, 32'hAB000000);
        do_xfer(1'b0, 32'h104, 3'd2, 32'h0);
        do_xfer(1'b1, 32'h108, 3'd2, 32'hAAAAAAAA);
        do_xfer(1'b1, 32'h10A, 3'd1, 32'h55660000);
        do_xfer(1'b1, 32'h108, 3'd1, 32'h00007788);
        do_xfer(1'b1, 32'h109, 3'd0, 32'h0000EE00);
        do_xfer(1'b0, 32'h108, 3'd2, 32'h0);
    endtask

    task automatic test_errors();
        sel = 0;
        do_xfer(1'b0, 32'h102, 3'd2, 32'h0);
        do_xfer(1'b0, 32'h1000, 3'd2, 32'h0);
        do_xfer(1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF);
        do_xfer(1'b1, 32'h101, 3'd1, 32'h12345678);
        do_xfer(1'b1, 32'h100, 3'd3, 32'h12345678);
        do_xfer(1'b0, 32'h100, 3'd2, 32'h0);
        do_xfer(1'b0, 32'h000, 3'd2, 32'h0);
    endtask

    task automatic test_idle_busy();
        sel = 0;
        @(negedge clk);
        drive_addr(1'b1, 32'h100, 3'd2);
        htrans = 2'b01;
        hwdata = 32'h0;
        @(negedge clk);
        checks++;
        if (hready_a[0] !== 1'b1 || hresp_a[0] !== 2'b00) begin
            errors++;
            $display("FAIL busy_zero_wait got hready=%b resp=%b want 1 00", hready_a[0], hresp_a[0]);
        end
        hsel_v = '0;
        htrans = 2'b10;
        @(negedge clk);
        checks++;
        if (hready_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL unselected_accept got hready=%b want 1", hready_a[0]);
        end
        drive_idle();
        do_xfer(1'b0, 32'h100, 3'd2, 32'h0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sel = 1;
        e.rdata = 32'h0; e.resp = 2'b00;
        sbq.push_back(e);
        model[key_of(1, 32'h200)] = 32'hCAFEF00D;
        e.rdata = model[key_of(1, 32'h200)];
        sbq.push_back(e);
        @(negedge clk);
        drive_addr(1'b1, 32'h200, 3'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (hready_a[1] !== 1'b1 || hrdata_a[1] !== e.rdata || hresp_a[1] !== e.resp) begin
                errors++;
                $display("FAIL pipelined_%0d got hready=%b rdata=%h resp=%b want 1 %h %b",
                         k, hready_a[1], hrdata_a[1], hresp_a[1], e.rdata, e.resp);
            end
            if (k == 0) begin
                hwdata = 32'hCAFEF00D;
                drive_addr(1'b0, 32'h200, 3'd2);
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic test_reset_mid_data();
        sel = 0;
        @(negedge clk);
        drive_addr(1'b0, 32'h100, 3'd2);
        @(negedge clk);
        drive_idle();
        checks++;
        if (hready_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_stall got hready=%b want 0", hready_a[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (hready_a[0] !== 1'b1 || hresp_a[0] !== 2'b00 || hrdata_a[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got hready=%b resp=%b rdata=%h want 1 00 0",
                     hready_a[0], hresp_a[0], hrdata_a[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (hready_a[0] !== 1'b1 || hresp_a[0] !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle got hready=%b resp=%b want 1 00", hready_a[0], hresp_a[0]);
        end
        do_xfer(1'b0, 32'h100, 3'd2, 32'h0);
    endtask

    task automatic test_abort_write();
        sel = 2;
        do_xfer(1'b1, 32'h300, 3'd2, 32'h11111111);
        @(negedge clk);
        drive_addr(1'b1, 32'h300, 3'd2);
        @(negedge clk);
        drive_idle();
        hwdata = 32'h22222222;
        @(negedge clk);
        checks++;
        if (hready_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall got hready=%b want 0", hready_a[2]);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_xfer(1'b0, 32'h300, 3'd2, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_subword();
        test_errors();
        test_idle_busy();
        test_back_to_back();
        test_reset_mid_data();
        test_abort_write();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_ram_slave.md
AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words (1024 words = 4 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte base address of the region, aligned to the region size.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0-15, meaning the HREADY-low cycles inserted per OKAY data phase.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports are named clk and reset.
REQ-005 Port list:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  address-phase byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; all other values are illegal.
- HWDATA  in  32  data-phase write data, already lane-positioned by the master.
- HRDATA  out  32  data-phase read data, full word.
- HREADY  out  1  transfer-done / slave-ready.
- HRESP  out  2  00 OKAY, 01 ERROR; 10 and 11 are never driven.

Function
REQ-006 SHALL accept an address phase ("accept") only when HSEL=1, HTRANS[1]=1 and HREADY=1 in the same cycle.
- On accept, SHALL capture HADDR, HWRITE and HSIZE.
- IDLE and BUSY transfers SHALL get zero-wait OKAY and cause no state change.
REQ-007 SHALL flag an accepted transfer as an error when any of the following holds:
- HADDR[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2].
- HSIZE is 011 or above.
- HSIZE=010 and HADDR[1:0]!=00.
- HSIZE=001 and HADDR[0]!=0.
REQ-008 SHALL implement the FSM {IDLE, DATA, ERR1, ERR2}; reset state is IDLE.
REQ-009 IDLE: HREADY=1, HRESP=OKAY, HRDATA=0.
- Accept without error -> DATA, with wait counter loaded to WAIT_STATES.
- Accept with error -> ERR1.
- Otherwise stay in IDLE.
REQ-010 DATA while counter!=0: HREADY=0, HRESP=OKAY, HRDATA=0; counter decrements each cycle.
REQ-011 DATA while counter=0 (completion cycle): HREADY=1, HRESP=OKAY.
- Read: HRDATA = mem[captured word index], combinational from the array.
- Write: HRDATA=0.
- Next state follows the same accept rules as REQ-009 (pipelined back-to-back transfers); no accept -> IDLE.
REQ-012 Write commit: at the rising edge that ends the completion cycle, write HWDATA lanes into mem under byte enables.
- Byte: lane HADDR[1:0].
- Halfword: lanes {1,0} if HADDR[1]=0, else {3,2}.
- Word: all four lanes.
- Lanes not enabled SHALL be unchanged.
REQ-013 ERR1: HREADY=0, HRESP=ERROR, HRDATA=0; unconditionally -> ERR2.
REQ-014 ERR2: HREADY=1, HRESP=ERROR, HRDATA=0; next state follows the accept rules of REQ-009.
REQ-015 An errored transfer SHALL never modify mem.
REQ-016 A read data phase immediately following a write to the same word SHALL return the newly written value, with no extra stall.
REQ-017 With WAIT_STATES=0, back-to-back OKAY transfers SHALL complete one per cycle.
REQ-018 HSEL=0 during a data phase SHALL NOT abort it; HSEL is sampled only at accept.

Reset
REQ-019 reset=0 SHALL immediately, asynchronously, force:
- state=IDLE, HREADY=1, HRESP=00, HRDATA=0;
- wait counter=0;
- captured address/control registers=0.
REQ-020 Reset asserted mid-transfer SHALL abort it; an uncommitted write is discarded.
REQ-021 mem contents SHALL NOT be reset; they are undefined until written.

Verification
REQ-022 Reset: assert reset=0 mid-DATA -> same cycle HREADY=1, HRESP=00, HRDATA=0; after release, the FSM is IDLE.
REQ-023 WAIT_STATES=1: word write 0x100 with HWDATA=0xDEADBEEF, then word read 0x100 -> read data phase has HREADY=0 for 1 cycle, then HREADY=1, HRDATA=0xDEADBEEF, HRESP=00.
REQ-024 Byte write: after word 0x11223344 at 0x104, byte write 0x107 with HWDATA=0xAB000000 -> word read 0x104 returns 0xAB223344.
REQ-025 Misaligned word read 0x102 -> ERR1 cycle (HREADY=0, HRESP=01), then ERR2 cycle (HREADY=1, HRESP=01); mem unchanged; an out-of-range address (0x0000_1000) gives the same response.
REQ-026 WAIT_STATES=0: pipelined write 0x200 = 0xCAFEF00D immediately followed by read 0x200 -> HREADY stays 1 throughout; read returns 0xCAFEF00D.
REQ-027 WAIT_STATES=3: reset pulsed during the second wait cycle of a write to 0x300 -> a later read of 0x300 returns the pre-write value.
